// File: rtl/boot_mem.sv
// Single-port program/data memory with a length-prefixed boot loader.
// Clears the array, loads the image at BOOT_BASE, then releases the CPU and serves 1-cycle reads.
module boot_mem #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned BOOT_BASE  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_ready,
   output logic                  cpu_rst_n,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] mem_in,
   output logic                  boot_done,
   output logic                  boot_err
);

   localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] MAX_LEN   = DATA_WIDTH'(DEPTH - BOOT_BASE);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BOOT_BASE);

   typedef enum logic [2:0] {S_CLEAR, S_HDR, S_LOAD, S_RUN, S_ERR} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
   logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
   logic [DATA_WIDTH-1:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0]   mem_in_q, mem_in_d;
   logic                    ld_ready_q, ld_ready_d;
   logic                    cpu_rst_n_q, cpu_rst_n_d;
   logic                    accept;
   logic                    ram_we;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic [DATA_WIDTH-1:0]   ram_wdata;
   logic [DATA_WIDTH-1:0]   ram_q [DEPTH];

   assign accept = ld_valid & ld_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_CLEAR;
         clr_q       <= '0;
         wptr_q      <= '0;
         rem_q       <= '0;
         ld_ready_q  <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         mem_in_q    <= '0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         wptr_q      <= wptr_d;
         rem_q       <= rem_d;
         ld_ready_q  <= ld_ready_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         mem_in_q    <= mem_in_d;
      end
   end

   // Array has no reset; the CLEAR sweep is what initialises it.
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_addr] <= ram_wdata;
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      wptr_d  = wptr_q;
      rem_d   = rem_q;
      case (state_q)
         S_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == LAST_ADDR) state_d = S_HDR;
         end
         S_HDR: begin
            if (accept) begin
               if (ld_data > MAX_LEN)  state_d = S_ERR;
               else if (ld_data == '0) state_d = S_RUN;
               else begin
                  state_d = S_LOAD;
                  wptr_d  = BASE_ADDR;
                  rem_d   = ld_data;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               wptr_d = wptr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == DATA_WIDTH'(1)) state_d = S_RUN;
            end
         end
         default: state_d = state_q;
      endcase
   end

   // Registered handshake/release flags follow the next state so they line up with it.
   always_comb begin
      ld_ready_d  = (state_d == S_HDR) || (state_d == S_LOAD);
      cpu_rst_n_d = (state_d == S_RUN);
      mem_in_d    = (state_q == S_RUN) ? ram_q[mem_addr] : '0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      case (state_q)
         S_CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = clr_q;
         end
         S_LOAD: begin
            ram_we    = accept;
            ram_addr  = wptr_q;
            ram_wdata = ld_data;
         end
         S_RUN: begin
            ram_we    = mem_we;
            ram_addr  = mem_addr;
            ram_wdata = mem_data;
         end
         default: ram_we = 1'b0;
      endcase
      if (rst) ram_we = 1'b0;
      boot_done = (state_q == S_RUN);
      boot_err  = (state_q == S_ERR);
   end

   assign ld_ready  = ld_ready_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign mem_in    = mem_in_q;

endmodule
